// File: rtl/keypad_entry_pkg.sv
// keypad_entry_pkg: shared constants, FSM states and key map for the keypad entry block
package keypad_entry_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {IDLE, CAND, HELD, REL} state_t;

    // Nibble at index {row, col}: row 0 = 1 2 3 A ... row 3 = * 0 # D
    localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return KEY_TABLE[{r, c, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad matrix lines and entry outputs of the keypad block
interface keypad_entry_if;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [3:0]  KEY;
    logic        KEY_VALID;
    logic [15:0] DIGITS;
    logic        LOAD;
    modport master (input ROW, output COL, KEY, KEY_VALID, DIGITS, LOAD);
    modport slave  (output ROW, input COL, KEY, KEY_VALID, DIGITS, LOAD);
endinterface

// File: rtl/DOWN_CNT.sv
// DOWN_CNT: enabled modulo prescaler, CEO pulses once every MODULO enabled cycles
module DOWN_CNT #(
    parameter int MODULO = 4
) (
    input  logic CLK,
    input  logic CLR,
    input  logic CE,
    output logic CEO
);
    localparam int W = $clog2(MODULO);
    logic [W-1:0] cnt;
    always_ff @(posedge CLK) begin
        if (CLR) cnt <= '0;
        else if (CE) cnt <= (cnt == '0) ? W'(MODULO - 1) : cnt - 1'b1;
    end
    assign CEO = CE && cnt == W'(1);
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 keypad, debounces per frame and builds a 4-digit BCD entry
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input logic            CLK,
    input logic            CLR,
    input logic            CE,
    keypad_entry_if.master kp
);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DF = CW'(DEBOUNCE_FRAMES);

    logic          tick, fe, accept;
    logic [3:0]    row_s1, row_s2;
    logic [1:0]    col, low_row;
    logic [2:0]    lows, tot;
    logic [1:0]    acc_n, m_n;
    logic [3:0]    acc_code, m_code;
    state_t        state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;

    DOWN_CNT #(.MODULO(SCAN_DIV)) u_pre (.CLK(CLK), .CLR(CLR), .CE(CE), .CEO(tick));

    assign kp.COL = ~(4'b0001 << col);

    // Low-row count saturates at 2: only NONE / SINGLE / MULTI matter per frame
    always_comb begin
        lows = 3'd0;
        low_row = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_s2[r]) begin
                lows = lows + 3'd1;
                low_row = 2'(r);
            end
        end
        tot = {1'b0, acc_n} + lows;
        m_n = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        m_code = (lows != 3'd0) ? key_code(low_row, col) : acc_code;
        fe = tick && col == 2'(NUM_COLS - 1);
    end

    always_comb begin
        state_n = state;
        cand_n = cand;
        cnt_n = cnt;
        accept = 1'b0;
        if (fe) begin
            case (state)
                IDLE: if (m_n == 2'd1) begin
                    state_n = CAND;
                    cand_n = m_code;
                    cnt_n = CW'(1);
                end
                CAND: if (m_n != 2'd1) state_n = IDLE;
                    else if (m_code != cand) begin
                        cand_n = m_code;
                        cnt_n = CW'(1);
                    end
                    else cnt_n = cnt + 1'b1;
                HELD: if (m_n == 2'd0) begin
                    state_n = REL;
                    cnt_n = CW'(1);
                end
                REL: if (m_n != 2'd0) state_n = HELD;
                    else cnt_n = cnt + 1'b1;
                default: state_n = IDLE;
            endcase
            if (state_n == CAND && cnt_n == DF) begin
                state_n = HELD;
                accept = 1'b1;
            end
            if (state_n == REL && cnt_n == DF) state_n = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
            col <= 2'd0;
            acc_n <= 2'd0;
            acc_code <= 4'd0;
            state <= IDLE;
            cand <= 4'd0;
            cnt <= '0;
            kp.KEY <= 4'd0;
            kp.KEY_VALID <= 1'b0;
            kp.DIGITS <= 16'd0;
            kp.LOAD <= 1'b0;
        end else begin
            row_s1 <= kp.ROW;
            row_s2 <= row_s1;
            if (tick) begin
                col <= col + 2'd1;
                acc_n <= fe ? 2'd0 : m_n;
                acc_code <= fe ? 4'd0 : m_code;
            end
            state <= state_n;
            cand <= cand_n;
            cnt <= cnt_n;
            kp.KEY_VALID <= accept;
            kp.LOAD <= accept && cand_n == KEY_HASH;
            if (accept) begin
                kp.KEY <= cand_n;
                kp.DIGITS <= (cand_n <= 4'd9) ? {kp.DIGITS[11:0], cand_n} :
                             (cand_n == KEY_STAR) ? 16'd0 : kp.DIGITS;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad matrix model, vector table and event scoreboard for keypad_entry
module tb_keypad_entry;

    typedef struct {
        logic [3:0]  code;
        int          frames;
        logic [15:0] digits;
        logic        load;
    } vec_t;

    typedef struct {
        logic [3:0]  key;
        logic [15:0] digits;
        logic        load;
    } exp_t;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    logic CE = 1'b1;
    logic [15:0] pressed = 16'd0;
    logic [3:0] row_v;
    int n_vec = 0;
    int n_bad = 0;
    int nev = 0;
    exp_t q[$];
    vec_t tbl[11];
    logic [3:0] km[16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] col_exp[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_entry_if kif();

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
        .CLK(CLK),
        .CLR(CLR),
        .CE(CE),
        .kp(kif)
    );

    always #5 CLK = ~CLK;

    // Matrix model: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row_v = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.COL[c]) row_v[r] = 1'b0;
    end
    assign kif.ROW = row_v;

    function automatic logic [15:0] kbit(input logic [3:0] code);
        kbit = 16'd0;
        for (int i = 0; i < 16; i++) if (km[i] == code) kbit[i] = 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic hold(input logic [15:0] m, input int frames);
        @(negedge CLK);
        pressed = m;
        repeat (frames * 16) @(negedge CLK);
    endtask

    task automatic expect_key(input logic [3:0] k, input logic [15:0] d, input logic l);
        exp_t e;
        e.key = k;
        e.digits = d;
        e.load = l;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (kif.KEY_VALID) begin
            nev++;
            if (q.size() == 0) chk("unexpected_event", {12'd0, kif.KEY, kif.DIGITS}, 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("key", 32'(kif.KEY), 32'(e.key));
                chk("digits", 32'(kif.DIGITS), 32'(e.digits));
                chk("load", 32'(kif.LOAD), 32'(e.load));
            end
        end else if (kif.LOAD) chk("load_without_valid", 32'(kif.LOAD), 32'd0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [3:0] c0;
        tbl[0]  = '{4'h5, 5, 16'h0005, 1'b0};
        tbl[1]  = '{4'h1, 3, 16'h0051, 1'b0};
        tbl[2]  = '{4'h2, 3, 16'h0512, 1'b0};
        tbl[3]  = '{4'h3, 3, 16'h5123, 1'b0};
        tbl[4]  = '{4'h4, 3, 16'h1234, 1'b0};
        tbl[5]  = '{4'h7, 3, 16'h2347, 1'b0};
        tbl[6]  = '{4'hF, 3, 16'h2347, 1'b1};
        tbl[7]  = '{4'hE, 3, 16'h0000, 1'b0};
        tbl[8]  = '{4'hA, 3, 16'h0000, 1'b0};
        tbl[9]  = '{4'h9, 3, 16'h0009, 1'b0};
        tbl[10] = '{4'h0, 3, 16'h0090, 1'b0};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_col", 32'(kif.COL), 32'h0E);
        chk("rst_key", 32'(kif.KEY), 32'd0);
        chk("rst_digits", 32'(kif.DIGITS), 32'd0);
        chk("rst_valid", 32'(kif.KEY_VALID), 32'd0);
        chk("rst_load", 32'(kif.LOAD), 32'd0);
        CLR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(posedge CLK);
            @(negedge CLK);
            chk("col_seq", 32'(kif.COL), 32'(col_exp[i]));
        end

        for (int i = 0; i < 11; i++) begin
            n0 = nev;
            expect_key(tbl[i].code, tbl[i].digits, tbl[i].load);
            hold(kbit(tbl[i].code), tbl[i].frames);
            hold(16'd0, 4);
            chk("press_events", 32'(nev - n0), 32'd1);
            chk("queue_empty", 32'(q.size()), 32'd0);
        end

        n0 = nev;
        hold(kbit(4'h8), 1);
        hold(16'd0, 1);
        hold(kbit(4'h8), 1);
        hold(16'd0, 3);
        chk("bounce_no_event", 32'(nev - n0), 32'd0);
        expect_key(4'h8, 16'h0908, 1'b0);
        hold(kbit(4'h8), 2);
        hold(16'd0, 4);
        chk("stable_events", 32'(nev - n0), 32'd1);
        chk("stable_queue", 32'(q.size()), 32'd0);

        n0 = nev;
        hold(kbit(4'h1) | kbit(4'h9), 4);
        chk("chord_no_event", 32'(nev - n0), 32'd0);
        expect_key(4'h1, 16'h9081, 1'b0);
        hold(kbit(4'h1), 4);
        chk("chord_release_event", 32'(nev - n0), 32'd1);
        hold(kbit(4'h1) | kbit(4'h9), 3);
        hold(16'd0, 4);
        chk("second_key_ignored", 32'(nev - n0), 32'd1);
        chk("chord_queue", 32'(q.size()), 32'd0);

        n0 = nev;
        expect_key(4'h6, 16'h0816, 1'b0);
        hold(kbit(4'h6), 1);
        CE = 1'b0;
        c0 = kif.COL;
        repeat (50) begin
            @(negedge CLK);
            chk("col_frozen", 32'(kif.COL), 32'(c0));
        end
        chk("ce_no_event", 32'(nev - n0), 32'd0);
        CE = 1'b1;
        hold(kbit(4'h6), 3);
        hold(16'd0, 4);
        chk("ce_resume_event", 32'(nev - n0), 32'd1);
        chk("ce_queue", 32'(q.size()), 32'd0);

        n0 = nev;
        hold(kbit(4'h3), 1);
        CLR = 1'b1;
        pressed = 16'd0;
        @(negedge CLK);
        CLR = 1'b0;
        hold(16'd0, 4);
        chk("clr_no_event", 32'(nev - n0), 32'd0);
        chk("clr_digits", 32'(kif.DIGITS), 32'd0);
        chk("clr_key", 32'(kif.KEY), 32'd0);

        n0 = nev;
        expect_key(4'h9, 16'h0009, 1'b0);
        hold(kbit(4'h9), 4);
        hold(16'd0, 4);
        chk("post_clr_event", 32'(nev - n0), 32'd1);
        chk("final_queue", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
